// File: rtl/sc_player_posreg_jug1.sv
// rtl/sc_player_posreg_jug1.sv - player-1 one-hot position register, edge comparator and move counter
// Optional SC_POSREG_JUG1_WRAP_EN: shifts rotate around the board edge and the side comparator is tied high.
module sc_player_posreg_jug1 #(
    parameter int DATAWIDTH_BUS = 8,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_POSITION = 8'b0001_0000,
    parameter int MOVECOUNT_WIDTH = 8
) (
    input  logic                       SC_STATEMACHINE_JUG1_CLOCK_50,
    input  logic                       SC_STATEMACHINE_JUG1_RESET_InHigh,
    input  logic                       SC_POSREG_JUG1_clear_InLow,
    input  logic                       SC_POSREG_JUG1_load0_InLow,
    input  logic [1:0]                 SC_POSREG_JUG1_shiftselection_In,
    input  logic [DATAWIDTH_BUS-1:0]   SC_POSREG_JUG1_data_In,
    input  logic                       SC_POSREG_JUG1_leftButton_InLow,
    input  logic                       SC_POSREG_JUG1_rightButton_InLow,
    output logic [DATAWIDTH_BUS-1:0]   SC_POSREG_JUG1_position_Out,
    output logic                       SC_POSREG_JUG1_sidecomparator_OutLow,
    output logic                       SC_POSREG_JUG1_atLeft_Out,
    output logic                       SC_POSREG_JUG1_atRight_Out,
    output logic [MOVECOUNT_WIDTH-1:0] SC_POSREG_JUG1_moveCount_Out,
    output logic                       SC_POSREG_JUG1_posValid_Out
);

    localparam logic [DATAWIDTH_BUS-1:0]   POS_ONE = {{(DATAWIDTH_BUS-1){1'b0}}, 1'b1};
    localparam logic [MOVECOUNT_WIDTH-1:0] CNT_ONE = {{(MOVECOUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATAWIDTH_BUS-1:0]   position_q, position_d;
    logic [MOVECOUNT_WIDTH-1:0] move_count_q, move_count_d;
    logic                       move_ok;
    logic                       at_left, at_right;

    assign at_left  = position_q[DATAWIDTH_BUS-1];
    assign at_right = position_q[0];

    always_comb begin
        position_d   = position_q;
        move_count_d = move_count_q;
        move_ok      = 1'b0;
        if (!SC_POSREG_JUG1_clear_InLow) begin
            position_d   = RESET_POSITION;
            move_count_d = '0;
        end else if (!SC_POSREG_JUG1_load0_InLow) begin
            position_d = SC_POSREG_JUG1_data_In;
        end else if (SC_POSREG_JUG1_shiftselection_In == 2'b01) begin
`ifdef SC_POSREG_JUG1_WRAP_EN
            position_d = {position_q[DATAWIDTH_BUS-2:0], position_q[DATAWIDTH_BUS-1]};
            move_ok    = 1'b1;
`else
            if (!at_left) begin
                position_d = position_q << 1;
                move_ok    = 1'b1;
            end
`endif
        end else if (SC_POSREG_JUG1_shiftselection_In == 2'b10) begin
`ifdef SC_POSREG_JUG1_WRAP_EN
            position_d = {position_q[0], position_q[DATAWIDTH_BUS-1:1]};
            move_ok    = 1'b1;
`else
            if (!at_right) begin
                position_d = position_q >> 1;
                move_ok    = 1'b1;
            end
`endif
        end
        // Counter saturates at all-ones instead of wrapping.
        if (move_ok && (move_count_q != '1)) begin
            move_count_d = move_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge SC_STATEMACHINE_JUG1_CLOCK_50 or posedge SC_STATEMACHINE_JUG1_RESET_InHigh) begin
        if (SC_STATEMACHINE_JUG1_RESET_InHigh) begin
            position_q   <= RESET_POSITION;
            move_count_q <= '0;
        end else begin
            position_q   <= position_d;
            move_count_q <= move_count_d;
        end
    end

    assign SC_POSREG_JUG1_position_Out  = position_q;
    assign SC_POSREG_JUG1_moveCount_Out = move_count_q;
    assign SC_POSREG_JUG1_atLeft_Out    = at_left;
    assign SC_POSREG_JUG1_atRight_Out   = at_right;
    assign SC_POSREG_JUG1_posValid_Out  = (position_q != '0) &&
                                          ((position_q & (position_q - POS_ONE)) == '0);

`ifdef SC_POSREG_JUG1_WRAP_EN
    assign SC_POSREG_JUG1_sidecomparator_OutLow = 1'b1;
`else
    assign SC_POSREG_JUG1_sidecomparator_OutLow =
        !((!SC_POSREG_JUG1_leftButton_InLow && at_left) ||
          (!SC_POSREG_JUG1_rightButton_InLow && at_right));
`endif

endmodule
